// File: rtl/pending_index_encoder.sv
// Purpose : multi-hot to index encoder; emits the index of every set bit of a
//           captured pending vector, one per handshake (lowest first, or
//           highest first when HIGH_FIRST_EN is defined).
// Latency : load at edge N -> first idx/valid registered at edge N; one index
//           per cycle while ready is held high.
// Backpr. : idx/valid are held stable while valid && !ready; valid is never
//           retracted except by clear or reset.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high
//   load   in   1      capture vec (only honoured when idle)
//   vec    in   WIDTH  pending vector
//   clear  in   1      abort current vector, back to idle, no done pulse
//   idx    out  IDX_W  index of current set bit
//   valid  out  1      idx is meaningful
//   ready  in   1      consumer accepts idx this cycle
//   busy   out  1      a vector is held (state != IDLE)
//   done   out  1      one-cycle pulse: vector drained or zero vector loaded
//
// Build option: define HIGH_FIRST_EN to scan from the highest set index down.
module pending_index_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] vec,
    input  logic             clear,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_remaining;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;

    logic             w_accept;
    logic [WIDTH-1:0] w_onehot;
    logic [WIDTH-1:0] w_next_rem;
    logic [IDX_W-1:0] w_next_idx;
    logic [IDX_W-1:0] w_load_idx;

    // Picks the first set bit in scan order. The loop walks in the opposite
    // direction so that the last match (the one that survives) is the
    // winner in the wanted order.
    function automatic logic [IDX_W-1:0] f_pick(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
`ifdef HIGH_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
`endif
        return r;
    endfunction

    // r_valid is only ever high in EMIT, so it doubles as the state qualifier.
    assign w_accept   = r_valid & ready;

    // Remaining bits once the currently presented index is accepted; the
    // following index is computed from this so it is ready at the same edge.
    assign w_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;
    assign w_next_rem = r_remaining & ~w_onehot;
    assign w_next_idx = f_pick(w_next_rem);
    assign w_load_idx = f_pick(vec);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
        end else if (clear) begin
            // clear outranks load and ready; no done pulse is produced.
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        if (vec != '0) begin
                            r_state     <= S_EMIT;
                            r_remaining <= vec;
                            r_idx       <= w_load_idx;
                            r_valid     <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_accept) begin
                        r_remaining <= w_next_rem;
                        if (w_next_rem == '0) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                        end else begin
                            r_idx <= w_next_idx;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_remaining <= '0;
                    r_valid     <= 1'b0;
                end
            endcase
        end
    end

    assign idx   = r_idx;
    assign valid = r_valid;
    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);

endmodule
